// File: rtl/ksa_pkg.sv
// Shared types and constants for the RC4 key-scheduling (KSA) stages.
//   state_t  : swap-phase FSM states
//   byte_t   : 8-bit S-memory datum / index
//   S_DEPTH  : number of S entries
//   LAST_IDX : final swap index
package ksa_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_SI   = 3'd1,
    WAIT_SI = 3'd2,
    RD_SJ   = 3'd3,
    WAIT_SJ = 3'd4,
    WR_SI   = 3'd5,
    WR_SJ   = 3'd6,
    DONE    = 3'd7
  } state_t;

  localparam int unsigned S_DEPTH  = 256;
  localparam byte_t       LAST_IDX = byte_t'(S_DEPTH - 1);

endpackage

// File: rtl/ksa_key_sel.sv
// Combinational key-byte selector: returns key byte k, where byte 0 is the
// most significant byte of the key vector.
//   key        : 8*KEY_LEN-bit key, MSB-first bytes
//   k          : key byte index (0..KEY_LEN-1)
//   key_byte_c : selected byte (combinational)
module ksa_key_sel
  import ksa_pkg::*;
#(
  parameter int unsigned KEY_LEN = 3,
  localparam int unsigned KW = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1
) (
  input  logic [8*KEY_LEN-1:0] key,
  input  logic [KW-1:0]        k,
  output byte_t                key_byte_c
);

  // One-hot style match over the byte lanes; out-of-range k yields zero.
  always_comb begin
    key_byte_c = '0;
    for (int unsigned n = 0; n < KEY_LEN; n++) begin
      if (k == KW'(n)) key_byte_c = key[8*(KEY_LEN-1-n) +: 8];
    end
  end

endmodule

// File: rtl/ksa_swap_fsm.sv
// RC4 key-scheduling swap-phase sequencer. Walks i = 0..255 over the single-
// port S memory: j += S[i] + key[i mod KEY_LEN]; swap S[i], S[j].
// Optional macro KSA_SAME_IDX_SKIP_EN: skip both writes when j == i.
//   clk, reset      : clock, synchronous active-high reset
//   start           : begin a pass (sampled in IDLE only)
//   key             : 8*KEY_LEN-bit key, byte 0 in the MSBs
//   mem_addr/wrdata/wren, mem_rddata : S memory port (1-cycle read latency)
//   busy            : high while the pass owns the memory port
//   done            : one-cycle completion pulse
module ksa_swap_fsm
  import ksa_pkg::*;
#(
  parameter int unsigned KEY_LEN = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [8*KEY_LEN-1:0] key,
  output byte_t                mem_addr,
  output byte_t                mem_wrdata,
  output logic                 mem_wren,
  input  byte_t                mem_rddata,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned KW     = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(KEY_LEN - 1);

  state_t        state, state_d;
  byte_t         i, i_d, j, j_d, si, si_d, sj, sj_d;
  logic [KW-1:0] k, k_d;
  byte_t         key_byte_c;
  logic          iter_end;
  byte_t         addr_d, wrdata_d;
  logic          wren_d, busy_d, done_d;

  ksa_key_sel #(.KEY_LEN(KEY_LEN)) u_key_sel (
    .key        (key),
    .k          (k),
    .key_byte_c (key_byte_c)
  );

  // State, datapath and registered memory-port outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      i          <= '0;
      j          <= '0;
      k          <= '0;
      si         <= '0;
      sj         <= '0;
      mem_addr   <= '0;
      mem_wrdata <= '0;
      mem_wren   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_d;
      i          <= i_d;
      j          <= j_d;
      k          <= k_d;
      si         <= si_d;
      sj         <= sj_d;
      mem_addr   <= addr_d;
      mem_wrdata <= wrdata_d;
      mem_wren   <= wren_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

  // Next state plus output decode. Outputs are decoded from the *next* state
  // so the registered port carries each state's values during that state.
  always_comb begin
    state_d  = state;
    i_d      = i;
    j_d      = j;
    k_d      = k;
    si_d     = si;
    sj_d     = sj;
    iter_end = 1'b0;
    addr_d   = '0;
    wrdata_d = '0;
    wren_d   = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          state_d = RD_SI;
        end
      end
      RD_SI:   state_d = WAIT_SI;
      WAIT_SI: begin
        si_d    = mem_rddata;
        j_d     = j + mem_rddata + key_byte_c;
        state_d = RD_SJ;
      end
      RD_SJ:   state_d = WAIT_SJ;
      WAIT_SJ: begin
        sj_d    = mem_rddata;
        state_d = WR_SI;
`ifdef KSA_SAME_IDX_SKIP_EN
        // Swapping an entry with itself is a no-op; go straight to the next i.
        if (j == i) iter_end = 1'b1;
`endif
      end
      WR_SI:   state_d = WR_SJ;
      WR_SJ:   iter_end = 1'b1;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Shared end-of-iteration advance; k wraps instead of using a modulo.
    if (iter_end) begin
      if (i == LAST_IDX) begin
        state_d = DONE;
      end else begin
        i_d     = i + 8'd1;
        k_d     = (k == K_LAST) ? '0 : k + KW'(1);
        state_d = RD_SI;
      end
    end

    case (state_d)
      RD_SI, WAIT_SI: begin
        addr_d = i_d;
        busy_d = 1'b1;
      end
      RD_SJ, WAIT_SJ: begin
        addr_d = j_d;
        busy_d = 1'b1;
      end
      WR_SI: begin
        addr_d   = i_d;
        wrdata_d = sj_d;
        wren_d   = 1'b1;
        busy_d   = 1'b1;
      end
      WR_SJ: begin
        addr_d   = j_d;
        wrdata_d = si_d;
        wren_d   = 1'b1;
        busy_d   = 1'b1;
      end
      DONE:    done_d = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ksa_swap_fsm.sv
// Self-checking bench for ksa_swap_fsm: behavioural 1-cycle-latency RAM plus a
// plain-arithmetic RC4 KSA reference model; directed and random keys.
module tb_ksa_swap_fsm;

  localparam int KL = 3;
`ifdef KSA_SAME_IDX_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset, start, init_req;
  logic [8*KL-1:0] key;
  logic [7:0]      mem_addr, mem_wrdata, mem_rddata;
  logic            mem_wren, busy, done;

  ksa_swap_fsm #(.KEY_LEN(KL)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .key        (key),
    .mem_addr   (mem_addr),
    .mem_wrdata (mem_wrdata),
    .mem_wren   (mem_wren),
    .mem_rddata (mem_rddata),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Behavioural S memory: registered address/data, q valid the next cycle.
  logic [7:0] ram [256];
  always @(posedge clk) begin
    if (init_req) begin
      for (int n = 0; n < 256; n++) ram[n] <= 8'(n);
    end else if (mem_wren) begin
      ram[mem_addr] <= mem_wrdata;
    end
    mem_rddata <= ram[mem_addr];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: final S, cumulative cycle count at each iteration end.
  logic [7:0] ref_s [256];
  int         ref_end [256];
  int         ref_eq;
  int         ref_done;

  task automatic model_ksa(input logic [8*KL-1:0] k);
    int j, t, kb;
    logic [7:0] tmp;
    j = 0;
    t = 0;
    ref_eq = 0;
    for (int n = 0; n < 256; n++) ref_s[n] = 8'(n);
    for (int i = 0; i < 256; i++) begin
      kb = int'(k >> (8 * (KL - 1 - (i % KL)))) & 255;
      j = (j + int'(ref_s[i]) + kb) % 256;
      if (j == i) ref_eq++;
      tmp      = ref_s[i];
      ref_s[i] = ref_s[j];
      ref_s[j] = tmp;
      t += (SKIP && j == i) ? 4 : 6;
      ref_end[i] = t;
    end
    ref_done = t + 1;
  endtask

  task automatic init_ram();
    @(negedge clk) init_req = 1'b1;
    @(negedge clk) init_req = 1'b0;
  endtask

  // mode: 0 none, 1 early-iteration snapshots (key 000249), 2 wrap snapshot,
  //       3 same-index iteration 0 (key 000000).
  task automatic run_pass(input logic [8*KL-1:0] k, input int mid_start,
                          input int rst_at, input int mode);
    int cyc, ndone, dcyc, nwren, nbad;
    bit stop;
    model_ksa(k);
    key = k;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1; ndone = 0; dcyc = 0; nwren = 0; stop = 1'b0;
    while (!stop && cyc < 2000) begin
      if (mem_wren) nwren++;
      if (done) begin
        ndone++;
        dcyc = cyc;
        check_val("busy_low_in_done", busy, 0);
      end
      if (mode == 1) begin
        if (cyc == ref_end[0] + 1) begin
          check_val("it0_s0", ram[0], 8'h00);
          check_val("it0_s1", ram[1], 8'h01);
        end
        if (cyc == ref_end[1] + 1) begin
          check_val("it1_s1", ram[1], 8'h03);
          check_val("it1_s3", ram[3], 8'h01);
        end
        if (cyc == ref_end[2] + 1) begin
          check_val("it2_s2", ram[2], 8'h4E);
          check_val("it2_s4e", ram[8'h4E], 8'h02);
        end
      end
      if (mode == 2 && cyc == ref_end[0] + 1) begin
        check_val("wrap_s0", ram[0], 8'hFF);
        check_val("wrap_sff", ram[8'hFF], 8'h00);
      end
      if (mode == 3) begin
`ifdef KSA_SAME_IDX_SKIP_EN
        if (cyc <= 4) check_val("same_no_wren", mem_wren, 0);
        if (cyc == 5) begin
          check_val("same_next_addr", mem_addr, 1);
          check_val("same_next_busy", busy, 1);
          check_val("same_next_wren", mem_wren, 0);
        end
`else
        if (cyc == 5 || cyc == 6) begin
          check_val("same_wren", mem_wren, 1);
          check_val("same_addr", mem_addr, 0);
          check_val("same_wrdata", mem_wrdata, 0);
        end
`endif
      end
      start = (cyc == mid_start);
      if (rst_at != 0 && cyc == rst_at) begin
        reset = 1'b1;
        @(posedge clk); #1;
        check_val("rst_wren", mem_wren, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_addr", mem_addr, 0);
        reset = 1'b0;
        stop  = 1'b1;
      end
      if (ndone > 0 && cyc >= dcyc + 3) stop = 1'b1;
      if (!stop) begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    start = 1'b0;
    if (rst_at == 0) begin
      check_val("done_pulses", ndone, 1);
      check_val("done_cycle", dcyc, ref_done);
      check_val("wren_cycles", nwren, 2 * (256 - (SKIP ? ref_eq : 0)));
      check_val("idle_busy", busy, 0);
      nbad = 0;
      for (int n = 0; n < 256; n++) if (ram[n] !== ref_s[n]) nbad++;
      check_val("final_s_bad_bytes", nbad, 0);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; key = '0; init_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_busy", busy, 0);
    check_val("reset_done", done, 0);
    check_val("reset_wren", mem_wren, 0);
    check_val("reset_addr", mem_addr, 0);
    reset = 1'b0;

    init_ram(); run_pass(24'h000249, 0, 0, 1);
    init_ram(); run_pass(24'hFFFFFF, 0, 0, 2);
    init_ram(); run_pass(24'h000249, 0, 700, 0);
    init_ram(); run_pass(24'(($urandom)), 0, 0, 0);
    init_ram(); run_pass(24'h000249, 100, 0, 0);
    init_ram(); run_pass(24'h000000, 0, 0, 3);
    repeat (3) begin
      init_ram(); run_pass(24'($urandom), 0, 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ksa_swap_fsm.md
Name: ksa_swap_fsm

Overview:
- Sequences the RC4 key-scheduling swap phase over the 256x8 single-port S memory (s_memory), after the init pass has loaded S[i]=i.
- For i = 0..255: j = j + S[i] + key[i mod KEY_LEN], then swap S[i] and S[j].
- Sits between the init FSM and the PRGA stage in ksa top; owns the S memory port only while busy.
- start/done handshake to the top-level sequencer.

Parameters:
- KEY_LEN, 3, number of key bytes; key port width is 8*KEY_LEN.

Ports:
- clk  input  1  system clock (CLOCK_50 domain)
- reset  input  1  synchronous, active-high reset
- start  input  1  begin a swap pass; sampled only in IDLE
- key  input  8*KEY_LEN  secret key; byte 0 = key[8*KEY_LEN-1 -: 8] (MSB first); must be stable while busy
- mem_addr  output  8  S memory address
- mem_wrdata  output  8  S memory write data
- mem_wren  output  1  S memory write enable
- mem_rddata  input  8  S memory q
- busy  output  1  high from first RD_SI cycle through last WR_SJ cycle
- done  output  1  one-cycle pulse on pass completion

Behaviour:
- Memory model: address/data/wren registered at clk edge; q valid during the following cycle.
- Reset (any state, including mid-pass): state=IDLE; i=0, j=0, key index k=0; mem_addr=0, mem_wrdata=0, mem_wren=0, busy=0, done=0. S contents are then partially swapped and undefined; a new init pass is required.
- Registers: i[7:0], j[7:0], k (0..KEY_LEN-1, wraps to 0 instead of a modulo), si[7:0], sj[7:0]. All sums are mod 256 (8-bit wrap, carry discarded).
- States and transitions:
  - IDLE: outputs 0. On start=1: i=0, j=0, k=0, go to RD_SI. start is ignored in every other state.
  - RD_SI: mem_addr=i, wren=0. Go to WAIT_SI.
  - WAIT_SI: mem_addr=i. Capture si=mem_rddata; j = j + mem_rddata + keybyte[k]. Go to RD_SJ.
  - RD_SJ: mem_addr=j (new value). Go to WAIT_SJ.
  - WAIT_SJ: mem_addr=j. Capture sj=mem_rddata. Go to WR_SI.
  - WR_SI: mem_addr=i, mem_wrdata=sj, wren=1. Go to WR_SJ.
  - WR_SJ: mem_addr=j, mem_wrdata=si, wren=1.
    - If i==255: go to DONE.
    - Else: i=i+1, k=(k==KEY_LEN-1)?0:k+1, go to RD_SI.
  - DONE: done=1, busy=0, wren=0. Go to IDLE.
- Latency: 6 cycles per iteration. First RD_SI is cycle 1; done is high in cycle 1537.
- i==j: both writes hit the same address and the second write wins; the value is unchanged (correct).
- mem_wren is high only in WR_SI and WR_SJ.
- Back-to-back: start held high through DONE launches a new pass from the IDLE cycle that follows.

Optional Feature:
- Macro: KSA_SAME_IDX_SKIP_EN.
- Defined: in WAIT_SJ, if j==i, skip WR_SI and WR_SJ and apply the WR_SJ next-state logic directly. That iteration takes 4 cycles, so total latency drops by 2 per equal-index iteration.
- Undefined: a fixed 6 cycles per iteration, as above.

Decomposition:
- Package ksa_pkg:
  - state_t enum: IDLE, RD_SI, WAIT_SI, RD_SJ, WAIT_SJ, WR_SI, WR_SJ, DONE.
  - typedef byte_t = logic[7:0].
  - S_DEPTH=256, LAST_IDX=8'd255.
- One combinational sub-module, ksa_key_sel: selects keybyte[k] from the key vector, parameterised by KEY_LEN.

Test Plan:
- Bench uses a behavioural RAM model with 1-cycle q and S preloaded to identity, key=24'h000249, pulse start.
  - After iteration 0: S unchanged (j=0).
  - After iteration 1: j=3, S[1]=3, S[3]=1.
  - After iteration 2: j=8'h4E, S[2]=8'h4E, S[8'h4E]=2.
- Full pass with the same key: final S matches the C reference model byte-for-byte; done high exactly in cycle 1537, single-cycle pulse; busy low in that cycle.
- Wrap check: key=24'hFFFFFF, identity S. Iteration 0: j=0+0+FF=8'hFF, so S[0]=8'hFF and S[8'hFF]=0 (sum wraps mod 256).
- Reset asserted at cycle 700: next cycle mem_wren=0, busy=0, done=0, state IDLE. A new start after re-init produces a correct full pass.
- start pulsed again mid-pass (cycle 100): ignored; i sequence and final S are unaffected, and only one done pulse occurs.
- KEY_LEN=1, key=8'h00, identity S:
  - Iteration 0 has i==j=0.
  - Without the macro: two writes of value 0 to address 0.
  - With KSA_SAME_IDX_SKIP_EN: no wren in iteration 0, and WAIT_SJ is followed by RD_SI with i=1.
